// File: rtl/segasys1_sndlatch.sv
// Sound-command queue from main CPU to sound CPU with per-command NMI pulse.
// Optional: define SEGASYS1_SNDLATCH_OVWR_EN so a push into a full queue overwrites the oldest entry.
module segasys1_sndlatch #(
  parameter int DEPTH   = 4,
  parameter int NMI_LEN = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          CLK48M,
  input  logic          RESET,
  input  logic          SNDRQ,
  input  logic [7:0]    SNDNO,
  input  logic          SRD,
  output logic [7:0]    SNDDO,
  output logic          SNMI,
  output logic          EMPTY,
  output logic          FULL,
  output logic          OVF,
  output logic [AW:0]   COUNT
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} nmi_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          sndrq_d, srd_d;
  logic          push, pop, pop_ok, full_push, do_wr, adv_rd;

  nmi_state_t    state, state_nxt;
  logic [7:0]    nmi_cnt, nmi_cnt_nxt;
  logic          acked, acked_nxt;

  // Strobe edge detection and queue bookkeeping
  always_comb begin
    push      = SNDRQ & ~sndrq_d;
    pop       = SRD & ~srd_d;
    pop_ok    = pop & (count != '0);
    full_push = push & ~pop_ok & (count == FULL_CNT);
`ifdef SEGASYS1_SNDLATCH_OVWR_EN
    do_wr     = push;
    adv_rd    = pop_ok | full_push;
`else
    do_wr     = push & ~full_push;
    adv_rd    = pop_ok;
`endif
    count_nxt = count;
    if (push && !pop_ok && !full_push)
      count_nxt = count + (AW+1)'(1);
    else if (pop_ok && !push)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge CLK48M) begin
    if (do_wr)
      mem[wr_ptr] <= SNDNO;
  end

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      sndrq_d <= 1'b0;
      srd_d   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      EMPTY   <= 1'b1;
      FULL    <= 1'b0;
      OVF     <= 1'b0;
      SNDDO   <= 8'h00;
    end else begin
      sndrq_d <= SNDRQ;
      srd_d   <= SRD;
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (adv_rd)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == FULL_CNT);
      if (full_push)
        OVF <= 1'b1;
      // Once the queue drains, SNDDO keeps the last byte handed out
      if (count != '0)
        SNDDO <= mem[rd_ptr];
    end
  end

  assign COUNT = count;

  // NMI sequencer: one pulse per command, re-armed by the sound CPU's read
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      state   <= IDLE;
      nmi_cnt <= 8'd0;
      acked   <= 1'b0;
    end else begin
      state   <= state_nxt;
      nmi_cnt <= nmi_cnt_nxt;
      acked   <= acked_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    nmi_cnt_nxt = nmi_cnt;
    acked_nxt   = acked;
    case (state)
      IDLE: begin
        acked_nxt = 1'b0;
        if (count != '0) begin
          nmi_cnt_nxt = 8'(NMI_LEN);
          state_nxt   = PULSE;
        end
      end
      PULSE: begin
        nmi_cnt_nxt = nmi_cnt - 8'd1;
        if (pop_ok)
          acked_nxt = 1'b1;
        if (nmi_cnt == 8'd1)
          state_nxt = (acked || pop_ok) ? IDLE : WAIT;
      end
      WAIT: begin
        if (pop_ok)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign SNMI = (state == PULSE);

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Bench for segasys1_sndlatch: directed scenarios plus random strobes against a queue-level model.
module tb_segasys1_sndlatch;

  localparam int DEPTH   = 4;
  localparam int NMI_LEN = 32;
  localparam int AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset, sndrq, srd;
  logic [7:0]    sndno;
  logic [7:0]    SNDDO;
  logic          SNMI, EMPTY, FULL, OVF;
  logic [AW:0]   COUNT;

  int vectors = 0;
  int miscompares = 0;

  // queue-level reference model
  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_snddo;
  logic       m_rq_d, m_rd_d;

  int snmi_run = 0;
  int pulses = 0;

  segasys1_sndlatch #(.DEPTH(DEPTH), .NMI_LEN(NMI_LEN)) dut (
    .CLK48M(clk), .RESET(reset), .SNDRQ(sndrq), .SNDNO(sndno), .SRD(srd),
    .SNDDO(SNDDO), .SNMI(SNMI), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .COUNT(COUNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic pe, po, was_reset;
    @(posedge clk);
    was_reset = reset;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_snddo = 8'h00; m_rq_d = 1'b0; m_rd_d = 1'b0;
    end else begin
      pe = sndrq & ~m_rq_d;
      po = srd & ~m_rd_d;
      m_rq_d = sndrq;
      m_rd_d = srd;
      if (q.size() > 0) m_snddo = q[0];
      if (po && q.size() > 0) void'(q.pop_front());
      if (pe) begin
        if (q.size() < DEPTH) q.push_back(sndno);
        else begin
          m_ovf = 1'b1;
`ifdef SEGASYS1_SNDLATCH_OVWR_EN
          void'(q.pop_front());
          q.push_back(sndno);
`endif
        end
      end
    end
    #1;
    chk("COUNT", 32'(COUNT), 32'(q.size()));
    chk("EMPTY", 32'(EMPTY), 32'(q.size() == 0));
    chk("FULL", 32'(FULL), 32'(q.size() == DEPTH));
    chk("OVF", 32'(OVF), 32'(m_ovf));
    chk("SNDDO", 32'(SNDDO), 32'(m_snddo));
    if (was_reset) begin
      chk("SNMI_RST", 32'(SNMI), 32'd0);
      snmi_run = 0;
    end else if (SNMI) begin
      snmi_run++;
    end else if (snmi_run != 0) begin
      chk("SNMI_LEN", 32'(snmi_run), 32'(NMI_LEN));
      pulses++;
      snmi_run = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cmd(input logic [7:0] b);
    sndno = b; sndrq = 1'b1;
    idle(16);
    sndrq = 1'b0;
    idle(16);
  endtask

  task automatic rd();
    srd = 1'b1;
    idle(16);
    srd = 1'b0;
    idle(16);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int p0, w, base;
    reset = 1'b1; sndrq = 1'b0; srd = 1'b0; sndno = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("RST_SNMI", 32'(SNMI), 32'd0);
    chk("RST_COUNT", 32'(COUNT), 32'd0);
    chk("RST_EMPTY", 32'(EMPTY), 32'd1);

    // single command
    p0 = pulses;
    sndno = 8'h5A; sndrq = 1'b1;
    tick();
    chk("S1_COUNT", 32'(COUNT), 32'd1);
    chk("S1_EMPTY", 32'(EMPTY), 32'd0);
    tick();
    chk("S1_SNDDO", 32'(SNDDO), 32'h5A);
    idle(14);
    sndrq = 1'b0;
    idle(40);
    chk("S1_PULSES", 32'(pulses - p0), 32'd1);
    rd();
    idle(40);
    chk("S1_POP_COUNT", 32'(COUNT), 32'd0);
    chk("S1_POP_SNMI", 32'(SNMI), 32'd0);
    chk("S1_NO_REPULSE", 32'(pulses - p0), 32'd1);

    // four queued commands
    p0 = pulses;
    for (int i = 1; i <= 4; i++) cmd(8'(i));
    idle(8);
    chk("S2_FULL", 32'(FULL), 32'd1);
    chk("S2_COUNT", 32'(COUNT), 32'd4);
    chk("S2_ONE_PULSE", 32'(pulses - p0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd();
      idle(40);
      chk("S2_HEAD", 32'(SNDDO), (i < 3) ? 32'(i + 2) : 32'h04);
    end
    chk("S2_PULSES", 32'(pulses - p0), 32'd4);
    chk("S2_EMPTY", 32'(EMPTY), 32'd1);

    // overflow
    for (int i = 0; i < 5; i++) cmd(8'(8'h10 + i));
    chk("S3_OVF", 32'(OVF), 32'd1);
    chk("S3_COUNT", 32'(COUNT), 32'd4);
`ifdef SEGASYS1_SNDLATCH_OVWR_EN
    base = 8'h11;
`else
    base = 8'h10;
`endif
    for (int i = 0; i < 4; i++) begin
      idle(4);
      chk("S3_POPVAL", 32'(SNDDO), 32'(base + i));
      rd();
    end
    chk("S3_OVF_STICKY", 32'(OVF), 32'd1);
    do_reset();
    chk("S3_OVF_CLR", 32'(OVF), 32'd0);

    // simultaneous push and pop with two entries
    cmd(8'h21); cmd(8'h22);
    sndno = 8'h23; sndrq = 1'b1; srd = 1'b1;
    idle(16);
    sndrq = 1'b0; srd = 1'b0;
    idle(16);
    chk("S4_COUNT2", 32'(COUNT), 32'd2);
    chk("S4_HEAD", 32'(SNDDO), 32'h22);
    rd(); rd();
    chk("S4_DRAINED", 32'(COUNT), 32'd0);
    // simultaneous on empty: pop discarded
    sndno = 8'h31; sndrq = 1'b1; srd = 1'b1;
    idle(16);
    sndrq = 1'b0; srd = 1'b0;
    idle(16);
    chk("S4_COUNT0", 32'(COUNT), 32'd1);
    chk("S4_SNDDO0", 32'(SNDDO), 32'h31);
    rd();

    // long strobes
    sndno = 8'h44; sndrq = 1'b1;
    idle(100);
    sndrq = 1'b0;
    idle(16);
    chk("S5_LONG_RQ", 32'(COUNT), 32'd1);
    rd();
    srd = 1'b1;
    idle(100);
    srd = 1'b0;
    idle(16);
    chk("S5_LONG_RD", 32'(COUNT), 32'd0);
    chk("S5_HOLD", 32'(SNDDO), 32'h44);

    // reset in the middle of a pulse with three entries
    idle(40);
    for (int i = 0; i < 4; i++) cmd(8'(8'h61 + i));
    idle(40);
    srd = 1'b1;
    tick();
    srd = 1'b0;
    w = 0;
    while (!SNMI && w < 10) begin tick(); w++; end
    chk("S6_PULSE_START", 32'(SNMI), 32'd1);
    idle(9);
    chk("S6_MID_SNMI", 32'(SNMI), 32'd1);
    chk("S6_MID_COUNT", 32'(COUNT), 32'd3);
    do_reset();
    chk("S6_SNMI", 32'(SNMI), 32'd0);
    chk("S6_COUNT", 32'(COUNT), 32'd0);
    chk("S6_OVF", 32'(OVF), 32'd0);
    chk("S6_SNDDO", 32'(SNDDO), 32'h00);

    // random strobes against the model
    for (int n = 0; n < 300; n++) begin
      int a;
      a = $urandom_range(0, 3);
      sndno = 8'($urandom);
      sndrq = (a == 0 || a == 2);
      srd   = (a == 1 || a == 2);
      idle($urandom_range(1, 20));
      sndrq = 1'b0; srd = 1'b0;
      idle($urandom_range(1, 20));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) rd();
    idle(80);
    chk("END_EMPTY", 32'(EMPTY), 32'd1);
    chk("END_SNMI", 32'(SNMI), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/segasys1_sndlatch.md
Name: segasys1_sndlatch

Overview:
- Sound-command queue between the main CPU and the sound CPU.
- Takes the one-CPU-clock sound-request pulse and command byte from the main CPU block and queues the byte.
- Raises an NMI request to the sound CPU for each queued byte and presents the head byte on the sound CPU's latch-read data bus.
- Runs entirely in the 48 MHz system clock domain; both CPU-rate strobes are edge-detected internally.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16; AW = log2(DEPTH)
NMI_LEN, 32, SNMI high time in CLK48M cycles; 1..255

Ports:
CLK48M  in  1  system clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
SNDRQ  in  1  sound request from main CPU; high for one CPU clock (about 16 CLK48M)
SNDNO  in  8  command byte; stable while SNDRQ is high
SRD  in  1  sound CPU latch-read strobe (level, CPU rate)
SNDDO  out  8  head command byte to the sound CPU data selector
SNMI  out  1  NMI request to the sound CPU
EMPTY  out  1  queue empty
FULL  out  1  queue holds DEPTH entries
OVF  out  1  sticky overflow flag
COUNT  out  AW+1  occupancy

Behaviour:
- Clock and reset: one clock, CLK48M. RESET is synchronous and active-high.
- Reset values: SNDDO=0x00, SNMI=0, EMPTY=1, FULL=0, OVF=0, COUNT=0, pointers=0, FSM=IDLE, edge registers=0.
- Edge detection:
  - push = SNDRQ & ~SNDRQ_d.
  - pop = SRD & ~SRD_d.
  - Each is a single-cycle event, so one CPU strobe produces exactly one push or one pop.
- Push: writes SNDNO at the write pointer, increments the write pointer mod DEPTH, COUNT+1.
- Pop: only when COUNT>0. Increments the read pointer mod DEPTH, COUNT-1. A pop when empty is ignored; no state changes.
- Simultaneous push and pop:
  - COUNT>0: both happen, COUNT unchanged.
  - COUNT=0: push only; the pop is discarded.
- Push when FULL and no pop: sets OVF. Data handling is per the Optional Feature.
- OVF clears only on RESET.
- SNDDO is registered and is always the head entry one cycle after the head changes:
  - after a push into an empty queue, SNDDO equals that byte one cycle later;
  - after a pop that leaves entries, SNDDO equals the new head one cycle later;
  - after a pop that empties the queue, SNDDO holds the last popped byte.
- EMPTY, FULL and COUNT are registered and reflect state after the current edge.
- Pointer wrap: pointers are AW bits and roll over from DEPTH-1 to 0. FULL and EMPTY are derived from COUNT, not from pointer compare.
- NMI FSM:
  - IDLE: SNMI=0. If COUNT>0, load counter=NMI_LEN and go to PULSE.
  - PULSE: SNMI=1; counter decrements each cycle; at counter=1 go to WAIT.
  - WAIT: SNMI=0. On pop go to IDLE. If entries remain, IDLE re-enters PULSE on the next cycle, giving a minimum 1-cycle SNMI gap between commands.
  - A pop during PULSE is accepted as a normal queue pop and the FSM goes to WAIT-satisfied: the pulse completes its full length, then the FSM returns to IDLE instead of waiting for another pop.
  - Pushes never restart or extend a pulse in progress.
- RESET mid-pulse: SNMI drops on the cycle after RESET is sampled; queue contents are discarded.

Optional Feature:
- Macro: SEGASYS1_SNDLATCH_OVWR_EN.
- Defined: a push when FULL overwrites the oldest entry.
  - The read pointer advances, the new byte is written, COUNT stays DEPTH, OVF=1.
  - SNDDO updates to the new head one cycle later.
  - The FSM is unaffected.
- Undefined: a push when FULL is dropped. Queue, pointers and SNDDO are unchanged; OVF=1.

Test Plan:
- Reset then single command: SNDRQ high for 16 cycles with SNDNO=0x5A.
  - Expect COUNT=1 and EMPTY=0 one cycle after the edge; SNDDO=0x5A the cycle after.
  - Expect SNMI high for exactly 32 cycles; pop via SRD gives COUNT=0 and SNMI stays 0.
- Queue four commands 0x01..0x04 with no reads: FULL=1, COUNT=4, a single SNMI pulse.
  - Pop four times: SNDDO steps 0x02, 0x03, 0x04 and holds 0x04; one SNMI pulse before each of the next three pops.
- Overflow: fill with 0x10..0x13, then push 0x14.
  - Without the macro: OVF=1 and pops return 0x10..0x13.
  - With the macro: OVF=1 and pops return 0x11..0x14.
- Simultaneous events:
  - SNDRQ and SRD edges on the same cycle with COUNT=2: COUNT stays 2, head advances.
  - Same with COUNT=0: COUNT=1 and SNDDO=the pushed byte.
- Long strobes: SNDRQ held high for 100 cycles gives exactly one push; SRD held high with an empty queue gives no change.
- Reset mid-pulse: assert RESET at cycle 10 of SNMI with COUNT=3.
  - Next cycle: SNMI=0, COUNT=0, OVF=0, SNDDO=0x00.
